camera_emulator: RTL
====================

CAMERA_EMULATOR -- requirements
Module: camera_emulator

Interface
REQ-001 The block SHALL expose parameter H_ACTIVE, default 320, active pixels per line (legal range 1..4095).
REQ-002 The block SHALL expose parameter V_ACTIVE, default 240, active lines per frame (legal range 1..4095).
REQ-003 The block SHALL expose parameter H_BLANK, default 16, pixel periods with lval low between lines (legal range 1..4095).
REQ-004 The block SHALL expose parameter V_BLANK, default 64, pixel periods with fval low after each frame (legal range 1..4095).
REQ-005 The block SHALL expose parameter FV_SETUP, default 2, pixel periods with fval high and lval low before the first line (legal range 1..4095).
REQ-006 Port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port trigger_n, input, 1 bit: active-low frame request from the camera receiver.
REQ-009 Port pixclk, output, 1 bit: emulated sensor pixel clock at clk/2.
REQ-010 Port fval, output, 1 bit: frame valid.
REQ-011 Port lval, output, 1 bit: line valid.
REQ-012 Port pixdata, output, 12 bits: pixel value.
REQ-013 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 pixclk SHALL toggle on every clk edge outside reset; one pixel period equals 2 clk cycles.
REQ-015 fval, lval, pixdata and the FSM SHALL update only on the clk edge where pixclk goes 1->0, so that they are stable at the following pixclk rising edge.
REQ-016 FSM states SHALL be IDLE, SETUP, ACTIVE, HBLANK and VBLANK.
REQ-017 IDLE -> SETUP SHALL occur on the first update edge with trigger_n=0; otherwise the FSM stays in IDLE.
REQ-018 SETUP: fval=1, lval=0 for FV_SETUP periods, then -> ACTIVE.
REQ-019 ACTIVE: fval=1, lval=1 for H_ACTIVE periods, with the x counter running 0..H_ACTIVE-1, then -> HBLANK.
REQ-020 HBLANK: fval=1, lval=0 for H_BLANK periods; then, if y<V_ACTIVE-1, y increments and the FSM goes -> ACTIVE; otherwise -> VBLANK.
REQ-021 VBLANK: fval=0, lval=0 for V_BLANK periods; then -> SETUP if trigger_n=0 (continuous mode), else -> IDLE.
REQ-022 pixdata SHALL equal (x+y) mod 4096 while lval=1, and 0 otherwise.
REQ-023 A trigger_n deassertion mid-frame SHALL NOT truncate the frame; it is evaluated only in IDLE and at the end of VBLANK.
REQ-024 The x, y and period counters SHALL be 12-bit and SHALL reset to 0 on each state entry (y resets on SETUP entry).

Reset
REQ-025 While reset=1 at a clk edge: state=IDLE, pixclk=0, fval=0, lval=0, pixdata=0, busy=0, and all counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; all outputs are at reset values by the next clk edge, and a new frame requires trigger_n=0 again.

Configuration
REQ-027 With macro CAMERA_EMULATOR_FRAME_COUNT_EN defined, a 16-bit output frame_count (reset 0) SHALL increment on each VBLANK entry (wrapping 0xFFFF->0), and pixel (0,0) of each frame SHALL carry frame_count[11:0] instead of 0.
REQ-028 Without CAMERA_EMULATOR_FRAME_COUNT_EN, the frame_count port and its logic SHALL be absent, and pixel (0,0) SHALL be 0.

Verification (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=3, FV_SETUP=1)
REQ-029 Single frame: trigger_n low for 1 period, then high -> fval high 1+2*(4+2)=13 periods; lval high in two runs of 4 periods; pixdata 0,1,2,3 then 1,2,3,4; then fval low 3 periods; then IDLE with busy=0.
REQ-030 Continuous: trigger_n held low -> back-to-back frames; VBLANK is exactly 3 periods between fval fall and the next fval rise.
REQ-031 Mid-frame release: trigger_n raised during line 0 -> the frame completes identically to REQ-029, and no second frame follows.
REQ-032 Reset at line 1, x=2 -> pixclk, fval, lval, pixdata and busy are all 0 one clk later; there is no activity until trigger_n=0.
REQ-033 Timing: at every pixclk rising edge, fval, lval and pixdata are unchanged from the previous clk edge.
REQ-034 With CAMERA_EMULATOR_FRAME_COUNT_EN: 3 continuous frames -> first pixel values 0,1,2; frame_count reads 3 after the third VBLANK entry.

Source files
------------

// File: rtl/camera_emulator.sv
// Camera-link style sensor emulator: pixclk at clk/2, fval/lval framing and a (x+y) test pattern.
// Optional per-frame counter stamped into pixel (0,0) when CAMERA_EMULATOR_FRAME_COUNT_EN is defined.
module camera_emulator #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_BLANK  = 64,
    parameter int unsigned FV_SETUP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger_n,
    output logic        pixclk,
    output logic        fval,
    output logic        lval,
    output logic [11:0] pixdata,
    output logic        busy
`ifdef CAMERA_EMULATOR_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSetup  = 3'd1;
    localparam logic [2:0] StActive = 3'd2;
    localparam logic [2:0] StHblank = 3'd3;
    localparam logic [2:0] StVblank = 3'd4;

    localparam logic [11:0] SetupLast  = 12'(FV_SETUP - 1);
    localparam logic [11:0] XLast      = 12'(H_ACTIVE - 1);
    localparam logic [11:0] YLast      = 12'(V_ACTIVE - 1);
    localparam logic [11:0] HblankLast = 12'(H_BLANK - 1);
    localparam logic [11:0] VblankLast = 12'(V_BLANK - 1);

    logic [2:0]  state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [11:0] cnt_q, cnt_d;
    logic        pixclk_q;
    logic        fval_q, fval_d;
    logic        lval_q, lval_d;
    logic [11:0] pix_q, pix_d;
    logic        update;

    // Everything except pixclk advances only where pixclk falls.
    assign update = pixclk_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        if (update) begin
            case (state_q)
                StIdle: begin
                    if (!trigger_n) begin
                        state_d = StSetup;
                        x_d     = '0;
                        y_d     = '0;
                        cnt_d   = '0;
                    end
                end
                StSetup: begin
                    if (cnt_q == SetupLast) begin
                        state_d = StActive;
                        x_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                StActive: begin
                    if (x_q == XLast) begin
                        state_d = StHblank;
                        x_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        x_d = x_q + 12'd1;
                    end
                end
                StHblank: begin
                    if (cnt_q == HblankLast) begin
                        cnt_d = '0;
                        x_d   = '0;
                        if (y_q < YLast) begin
                            state_d = StActive;
                            y_d     = y_q + 12'd1;
                        end else begin
                            state_d = StVblank;
                        end
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                StVblank: begin
                    if (cnt_q == VblankLast) begin
                        cnt_d = '0;
                        x_d   = '0;
                        if (!trigger_n) begin
                            state_d = StSetup;
                            y_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef CAMERA_EMULATOR_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (update && (state_q != StVblank) && (state_d == StVblank)) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
`endif

    // Outputs are derived from the next state so they line up with the state they describe.
    always_comb begin
        fval_d = (state_d == StSetup) || (state_d == StActive) || (state_d == StHblank);
        lval_d = (state_d == StActive);
        pix_d  = '0;
        if (lval_d) begin
            pix_d = x_d + y_d;
`ifdef CAMERA_EMULATOR_FRAME_COUNT_EN
            if ((x_d == '0) && (y_d == '0)) begin
                pix_d = frame_count_q[11:0];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            pixclk_q <= 1'b0;
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            pix_q    <= '0;
`ifdef CAMERA_EMULATOR_FRAME_COUNT_EN
            frame_count_q <= '0;
`endif
        end else begin
            pixclk_q <= ~pixclk_q;
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            if (update) begin
                fval_q <= fval_d;
                lval_q <= lval_d;
                pix_q  <= pix_d;
            end
`ifdef CAMERA_EMULATOR_FRAME_COUNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    assign pixclk  = pixclk_q;
    assign fval    = fval_q;
    assign lval    = lval_q;
    assign pixdata = pix_q;
    assign busy    = (state_q != StIdle);

endmodule
